// File: rtl/tlb_walker.sv
// Radix page-table walker refilling the TLB from a (va, pcid) miss.
// Latency: LEVELS*(req wait + rsp wait + 2) + 1 cycles from miss accept to insert/fault.
// Backpressure: miss_ready only in IDLE; PTE request held stable until mem_req_ready.
//
// Ports:
//   clk, shutdown_n              clock, async active-low reset
//   root_pa                      table root, sampled when a miss is accepted
//   miss_valid/ready, miss_va, miss_pcid       miss request (ready high only in IDLE)
//   mem_req_valid/ready, mem_req_addr          PTE read request (8-byte PTEs)
//   mem_rsp_valid, mem_rsp_data                PTE data, one response per request
//   insert, ins_va, ins_pa, ins_pcid           one-cycle TLB fill; ins_* hold between fills
//   fault                                      one-cycle pulse on a non-present PTE
//   busy                                       high whenever not IDLE
module tlb_walker #(
  parameter int LEVELS     = 4,
  parameter int IDX_W      = 9,
  parameter int PAGE_SHIFT = 12
) (
  input  logic        clk,
  input  logic        shutdown_n,
  input  logic [63:0] root_pa,
  input  logic        miss_valid,
  input  logic [63:0] miss_va,
  input  logic [11:0] miss_pcid,
  output logic        miss_ready,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        insert,
  output logic [63:0] ins_va,
  output logic [63:0] ins_pa,
  output logic [11:0] ins_pcid,
  output logic        fault,
  output logic        busy
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(LEVELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state;
  logic [LVL_W-1:0] lvl;
  logic [63:0]      va_q;
  logic [11:0]      pcid_q;

  // PTE flag/reserved bits other than present are don't-care for the walk.
  logic unused_pte_bits;
  assign unused_pte_bits = ^{mem_rsp_data[63:52], mem_rsp_data[11:1]};

  // Byte address of the PTE selected by va at level l under table base.
  // Arithmetic deliberately wraps modulo 2^64.
  function automatic logic [63:0] pte_addr(input logic [63:0]      base,
                                           input logic [63:0]      va,
                                           input logic [LVL_W-1:0] l);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(va >> (PAGE_SHIFT + IDX_W * int'(l)));
    return base + ({{(64 - IDX_W){1'b0}}, idx} << 3);
  endfunction

  always_ff @(posedge clk or negedge shutdown_n) begin
    if (!shutdown_n) begin
      state         <= S_IDLE;
      lvl           <= TOP_LVL;
      va_q          <= '0;
      pcid_q        <= '0;
      miss_ready    <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      insert        <= 1'b0;
      fault         <= 1'b0;
      busy          <= 1'b0;
      ins_va        <= '0;
      ins_pa        <= '0;
      ins_pcid      <= '0;
    end else begin
      // Strobes are single-cycle by construction.
      insert <= 1'b0;
      fault  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss_valid) begin
            va_q          <= miss_va;
            pcid_q        <= miss_pcid;
            lvl           <= TOP_LVL;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= pte_addr(root_pa, miss_va, TOP_LVL);
            miss_ready    <= 1'b0;
            busy          <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (!mem_rsp_data[0]) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else if (lvl == '0) begin
              insert   <= 1'b1;
              ins_va   <= va_q;
              ins_pa   <= {12'b0, mem_rsp_data[51:12], va_q[11:0]};
              ins_pcid <= pcid_q;
              state    <= S_DONE;
            end else begin
              // Next-level table base comes straight from the PTE's PPN.
              lvl           <= lvl - 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= pte_addr({12'b0, mem_rsp_data[51:12], 12'b0}, va_q, lvl - 1'b1);
              state         <= S_REQ;
            end
          end
        end
        S_DONE, S_FAULT: begin
          miss_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          miss_ready    <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_walker.sv
module tb_tlb_walker;

  logic        clk;
  logic        shutdown_n;
  logic [63:0] root_pa;
  logic        miss_valid;
  logic [63:0] miss_va;
  logic [11:0] miss_pcid;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        insert;
  logic [63:0] ins_va;
  logic [63:0] ins_pa;
  logic [11:0] ins_pcid;
  logic        fault;
  logic        busy;

  tlb_walker dut (
    .clk          (clk),
    .shutdown_n   (shutdown_n),
    .root_pa      (root_pa),
    .miss_valid   (miss_valid),
    .miss_va      (miss_va),
    .miss_pcid    (miss_pcid),
    .miss_ready   (miss_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .insert       (insert),
    .ins_va       (ins_va),
    .ins_pa       (ins_pa),
    .ins_pcid     (ins_pcid),
    .fault        (fault),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [63:0] VA = 64'hffff_ffff_ffff_fff1;

  typedef struct {
    bit          is_fault;
    logic [63:0] va;
    logic [63:0] pa;
    logic [11:0] pcid;
    int          lat;
  } exp_t;

  exp_t        exp_out_q[$];
  logic [63:0] exp_req_q[$];
  int          acc_q[$];
  logic [63:0] walk_addr[4];
  logic [63:0] pte_mem[logic [63:0]];

  int total = 0;
  int bad   = 0;

  // Memory-model controls: main process raises *_n, memory process counts *_done.
  int stall_n = 0, stall_done = 0;
  int spur_req_n = 0, spur_req_done = 0;
  int spur_any_n = 0, spur_any_done = 0;
  bit hs_pending = 0;
  logic [63:0] hs_addr = '0;

  // Monitor state.
  int   cyc = 0;
  int   last_ins = -100;
  bit   b2b_chk = 0;
  bit   prev_stall = 0;
  logic [63:0] prev_addr = '0;
  exp_t e;
  int   acc_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name, input string detail);
    total++;
    bad++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  function automatic logic [63:0] lookup(input logic [63:0] a);
    return pte_mem.exists(a) ? pte_mem[a] : 64'h0;
  endfunction

  // Memory: zero-wait responder with optional request stalls and stray responses.
  initial begin
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (hs_pending) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = lookup(hs_addr);
        hs_pending    = 0;
      end else if (spur_any_done < spur_any_n) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0000_0000_0009_9001;
        spur_any_done++;
      end else if (spur_req_done < spur_req_n && mem_req_valid) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0;
        spur_req_done++;
      end
      if (mem_req_valid && stall_done < stall_n) begin
        mem_req_ready = 1'b0;
        stall_done++;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        hs_pending = 1;
        hs_addr    = mem_req_addr;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!shutdown_n) begin
        acc_q.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("req_hold_valid", 64'(mem_req_valid), 64'd1);
          chk("req_hold_addr", mem_req_addr, prev_addr);
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        if (miss_valid && miss_ready) begin
          acc_q.push_back(cyc);
          if (b2b_chk) begin
            chk("b2b_accept_gap", 64'(cyc - last_ins), 64'd1);
            b2b_chk = 0;
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          if (exp_req_q.size() == 0)
            note_fail("unexpected_req", $sformatf("actual addr=%h required=none", mem_req_addr));
          else
            chk("req_addr", mem_req_addr, exp_req_q.pop_front());
        end
      end
      if (insert && fault)
        note_fail("insert_and_fault", "actual both high required at most one");
      if (insert || fault) begin
        if (exp_out_q.size() == 0) begin
          note_fail("unexpected_output",
                    $sformatf("actual insert=%0b fault=%0b required=none", insert, fault));
        end else begin
          e       = exp_out_q.pop_front();
          acc_cyc = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
          chk("out_is_fault", 64'(fault), 64'(e.is_fault));
          chk("out_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          chk("ins_va", ins_va, e.va);
          chk("ins_pa", ins_pa, e.pa);
          chk("ins_pcid", 64'(ins_pcid), 64'(e.pcid));
          if (insert) last_ins = cyc;
        end
      end
    end
  end

  task automatic push_reqs(input int n);
    for (int i = 0; i < n; i++) exp_req_q.push_back(walk_addr[i]);
  endtask

  task automatic push_out(input bit f, input logic [63:0] va, input logic [63:0] pa,
                          input logic [11:0] pcid, input int lat);
    exp_t x;
    x.is_fault = f;
    x.va       = va;
    x.pa       = pa;
    x.pcid     = pcid;
    x.lat      = lat;
    exp_out_q.push_back(x);
  endtask

  // Presents a miss until accepted; returns on the negedge after the accepting edge.
  task automatic issue_miss(input logic [63:0] va, input logic [11:0] pcid, input bit drop);
    bit got;
    got = 0;
    @(negedge clk);
    miss_valid = 1'b1;
    miss_va    = va;
    miss_pcid  = pcid;
    for (int n = 0; n < 100 && !got; n++) begin
      #1;
      if (miss_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) note_fail("miss_accept_timeout", "actual miss_ready=0 required=1 within 100 cycles");
    @(negedge clk);
    if (drop) miss_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (!busy && miss_ready && !insert && !fault) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual busy=%0b required idle within 200 cycles", name, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    walk_addr[0] = 64'h1FF8;
    walk_addr[1] = 64'h2FF8;
    walk_addr[2] = 64'h3FF8;
    walk_addr[3] = 64'h4FF8;
    // Ignored PTE bits are set on some entries to check they are masked.
    pte_mem[64'h1FF8] = 64'h8000_0000_0000_2003;
    pte_mem[64'h2FF8] = 64'h0000_0000_0000_3001;
    pte_mem[64'h3FF8] = 64'h0000_0000_0000_4001;
    pte_mem[64'h4FF8] = 64'hFFF0_0000_0000_5FFF;

    shutdown_n = 1'b0;
    root_pa    = 64'h1000;
    miss_valid = 1'b0;
    miss_va    = '0;
    miss_pcid  = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_miss_ready", 64'(miss_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_insert", 64'(insert), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_ins_pa", ins_pa, 64'd0);
    chk("rst_ins_pcid", 64'(ins_pcid), 64'd0);
    @(negedge clk);
    shutdown_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: full four-level walk, zero-wait memory
    push_reqs(4);
    push_out(0, VA, 64'h5ff1, 12'd1, 9);
    issue_miss(VA, 12'd1, 1);
    wait_idle("s2_idle");

    // 3: non-present level-2 PTE faults; ins_* keep the previous fill
    pte_mem[64'h2FF8] = 64'h0;
    push_reqs(2);
    push_out(1, VA, 64'h5ff1, 12'd1, 5);
    issue_miss(VA, 12'd2, 1);
    wait_idle("s3_idle");
    pte_mem[64'h2FF8] = 64'h0000_0000_0000_3001;

    // 4: five-cycle request stall at level 3
    stall_n += 5;
    push_reqs(4);
    push_out(0, VA, 64'h5ff1, 12'd3, 14);
    issue_miss(VA, 12'd3, 1);
    wait_idle("s4_idle");

    // 5: miss_valid held through the walk; second walk right after insert
    spur_req_n += 1;
    push_reqs(4);
    push_out(0, VA, 64'h5ff1, 12'd1, 9);
    push_reqs(4);
    push_out(0, VA, 64'h5ff1, 12'd0, 9);
    issue_miss(VA, 12'd1, 0);
    b2b_chk   = 1;
    miss_pcid = 12'd0;
    issue_miss(VA, 12'd0, 1);
    wait_idle("s5_idle");
    chk("s5_b2b_checked", 64'(b2b_chk), 64'd0);

    // 6: reset during the level-1 WAIT, stray responses afterwards
    push_reqs(3);
    issue_miss(VA, 12'd5, 1);
    repeat (5) @(negedge clk);
    shutdown_n = 1'b0;
    #1;
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_miss_ready", 64'(miss_ready), 64'd1);
    chk("s6_rst_req_valid", 64'(mem_req_valid), 64'd0);
    repeat (2) @(negedge clk);
    shutdown_n = 1'b1;
    spur_any_n += 1;
    repeat (4) @(negedge clk);
    #1;
    chk("s6_after_busy", 64'(busy), 64'd0);
    chk("s6_after_ins_pa", ins_pa, 64'd0);
    chk("s6_req_left", 64'(exp_req_q.size()), 64'd0);
    push_reqs(4);
    push_out(0, VA, 64'h5ff1, 12'd7, 9);
    issue_miss(VA, 12'd7, 1);
    wait_idle("s6_idle");

    chk("exp_out_left", 64'(exp_out_q.size()), 64'd0);
    chk("exp_req_left", 64'(exp_req_q.size()), 64'd0);
    chk("final_ins_pcid", 64'(ins_pcid), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
